codec_cfg_sequencer: RTL and testbench
======================================

Name: codec_cfg_sequencer

Overview:
- Owns the codec's I2C configuration path inside the codec unit; sits between the register block and the I2C controller.
- After reset or a restart pulse, walks a fixed table of codec register writes (SSM2603 format: 7-bit reg addr, 9-bit data) and issues each one to the I2C controller.
- Once init completes, arbitrates single software writes from the AXI register block onto the same I2C controller, with NACK retry and status reporting.

Parameters:
- NUM_INIT_WORDS, 10, entries used from the package init table (1..16).
- MAX_RETRY, 3, re-issues of one word after NACK before declaring error (0..7).
- ACTIVATE_DELAY_CYCLES, 24'd6_250_000, wait before the final (activate) word; 50 ms at 125 MHz.

Ports:
- board_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- init_start  in  1  single-cycle pulse; restarts init (driven from the controller_reset register bit).
- sw_valid  in  1  software write request.
- sw_ready  out  1  request accepted this cycle when sw_valid & sw_ready.
- sw_addr  in  7  codec register address.
- sw_data  in  9  codec register data.
- i2c_valid  out  1  command to the I2C controller.
- i2c_ready  in  1  controller accepts when i2c_valid & i2c_ready.
- i2c_word  out  16  {addr[6:0], data[8:0]}.
- i2c_done  in  1  one-cycle pulse at transaction end.
- i2c_nack  in  1  qualified by i2c_done; 1 means NACK.
- init_done  out  1  sticky once the table completes successfully.
- busy  out  1  any transaction in flight or init running.
- error  out  1  sticky; retries exhausted.
- err_addr  out  7  register address of the failing word.
- retry_cnt_total  out  8  saturating count of NACK retries since reset.

Behaviour:
- Reset values:
  - Register and handshake outputs: i2c_valid=0, i2c_word=0, sw_ready=0, init_done=0, busy=0, error=0, err_addr=0, retry_cnt_total=0.
  - FSM goes to INIT_LOAD, so init runs automatically after reset.
- FSM states: IDLE, INIT_LOAD, INIT_ISSUE, INIT_WAIT, INIT_DELAY, SW_ISSUE, SW_WAIT, FAULT.
- INIT_LOAD:
  - Load word idx from the table; idx starts at 0; clear the retry counter.
  - If idx == NUM_INIT_WORDS-1 and the delay feature is on, go to INIT_DELAY; otherwise go to INIT_ISSUE.
- INIT_ISSUE: i2c_valid=1 and i2c_word stable until i2c_ready; then INIT_WAIT. i2c_valid drops the cycle after the handshake.
- INIT_WAIT, on i2c_done:
  - ACK: idx+1. If idx was the last word, set init_done and go to IDLE; otherwise go to INIT_LOAD.
  - NACK with retry < MAX_RETRY: retry+1, retry_cnt_total+1 (saturating at 255), back to INIT_ISSUE.
  - NACK with retries exhausted: error=1, err_addr=word addr, go to FAULT.
- INIT_DELAY: count ACTIVATE_DELAY_CYCLES cycles, then INIT_ISSUE.
- IDLE:
  - sw_ready=1 only in IDLE with init_done=1; a handshake latches addr/data and moves to SW_ISSUE.
  - sw_ready is combinational from state, so it is never high while busy.
- SW_ISSUE and SW_WAIT follow the INIT_ISSUE/INIT_WAIT rules, including retry. Success returns to IDLE; exhaustion sets error and err_addr and goes to FAULT.
- FAULT: i2c_valid=0 and sw_ready=0; the block holds until init_start or reset.
- init_start:
  - Accepted in any state except INIT_ISSUE/SW_ISSUE with i2c_valid high. There it is latched and acted on after the current transaction's i2c_done, so no command is truncated mid-handshake.
  - On accept: clear init_done, error, err_addr; set idx=0; go to INIT_LOAD. retry_cnt_total is not cleared.
- Arbitration: init always has priority. Software is blocked (sw_ready=0) from reset or init_start until init_done.
- sw_valid and init_start in the same cycle in IDLE: init_start wins and the software request is not accepted.
- i2c_done outside a WAIT state is ignored.
- Reset mid-transaction drops i2c_valid the next cycle; the I2C controller is reset by the same signal.
- busy=1 in every state except IDLE and FAULT.

Optional Feature:
- Macro: CODEC_SEQ_ACTIVATE_DELAY_EN.
- Defined: INIT_DELAY is inserted before the last table word (the codec activate write, reg 0x09), allowing VMID settle.
- Undefined: the INIT_DELAY state and its 24-bit counter are absent; the last word issues immediately after the previous ACK.

Decomposition:
- Package codec_cfg_pkg holds:
  - typedef codec_word_t (struct: addr 7, data 9);
  - localparam array CODEC_INIT_TABLE[16] (reset 0x0F=0, power 0x06, line-in, headphone, analog path 0x04, digital path 0x05, interface 0x07, sample rate 0x08, power final, active 0x09=1);
  - the state enum;
  - CODEC_I2C_DEV_ADDR=7'h1A.
- Sub-module codec_retry_ctrl holds the retry counter, the exhaustion flag and the saturating total counter; it is shared by the init and software paths.

Test Plan:
- Reset, then i2c_ready=1 and ACK every command → 10 words issued in table order. The 10th is preceded by ≥6_250_000 idle cycles when the feature is defined. init_done=1, busy=0.
- NACK word 2 twice, then ACK → word 2 reissued twice, retry_cnt_total=2, init completes, error=0.
- NACK word 3 four times with MAX_RETRY=3 → error=1, err_addr=word 3 addr, FSM in FAULT, sw_ready=0. A following init_start clears error and restarts at word 0.
- After init_done, sw_valid with addr=7'h04, data=9'h012 → sw_ready handshake, then i2c_word=16'h0812. busy stays high until i2c_done, then sw_ready=1 again.
- sw_valid held during init → never accepted until init_done. init_start and sw_valid in the same IDLE cycle → init restarts and the software write is not issued.
- init_start asserted while i2c_valid=1 and i2c_ready=0 → i2c_word is unchanged until the handshake and that transaction's i2c_done, then the restart issues word 0.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer:
// codec word format, the power-up register table and the FSM state encoding.
package codec_cfg_pkg;

   localparam logic [6:0] CODEC_I2C_DEV_ADDR = 7'h1A;
   localparam int         RETRY_CNT_W        = 3;

   // SSM2603 register write: 7-bit register address, 9-bit data
   typedef struct packed {
      logic [6:0] addr;
      logic [8:0] data;
   } codec_word_t;

   typedef enum logic [2:0] {
      IDLE,
      INIT_LOAD,
      INIT_ISSUE,
      INIT_WAIT,
      INIT_DELAY,
      SW_ISSUE,
      SW_WAIT,
      FAULT
   } seq_state_t;

   // Power-up sequence; the last used entry must be the activate write (0x09)
   localparam codec_word_t CODEC_INIT_TABLE [16] = '{
      '{7'h0F, 9'h000},   // software reset
      '{7'h06, 9'h010},   // power: all up except outputs
      '{7'h00, 9'h017},   // left line-in, 0 dB
      '{7'h02, 9'h079},   // left headphone, 0 dB
      '{7'h04, 9'h012},   // analog path: DAC select, line-in to ADC
      '{7'h05, 9'h000},   // digital path: no de-emphasis, DAC unmuted
      '{7'h07, 9'h00A},   // interface: I2S, 24-bit, slave
      '{7'h08, 9'h000},   // sample rate: 48 kHz normal mode
      '{7'h06, 9'h000},   // power: outputs up
      '{7'h09, 9'h001},   // activate digital core
      '{7'h00, 9'h000},
      '{7'h00, 9'h000},
      '{7'h00, 9'h000},
      '{7'h00, 9'h000},
      '{7'h00, 9'h000},
      '{7'h00, 9'h000}
   };

endpackage

// File: rtl/codec_cfg_sequencer_retry.sv
// Per-word NACK retry counter with exhaustion flag, plus a saturating
// count of all retries since reset. Shared by the init and software paths.
module codec_retry_ctrl
   import codec_cfg_pkg::*;
#(
   parameter int MAX_RETRY = 3
) (
   input  logic       board_clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       nack,
   output logic       exhausted,
   output logic [7:0] retry_cnt_total
);

   logic [RETRY_CNT_W-1:0] retry_cnt;

   assign exhausted = (retry_cnt >= RETRY_CNT_W'(MAX_RETRY));

   // count retries of the current word and in total; a NACK once exhausted is not a retry
   always_ff @(posedge board_clk) begin
      if (reset) begin
         retry_cnt       <= '0;
         retry_cnt_total <= '0;
      end else begin
         if (clr)
            retry_cnt <= '0;
         else if (nack && !exhausted)
            retry_cnt <= retry_cnt + 1'b1;
         if (nack && !exhausted && retry_cnt_total != 8'hFF)
            retry_cnt_total <= retry_cnt_total + 8'd1;
      end
   end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec I2C configuration sequencer: runs the power-up register table after
// reset or init_start, then forwards single software writes to the I2C
// controller, with NACK retry and sticky error reporting.
// Optional: define CODEC_SEQ_ACTIVATE_DELAY_EN to wait ACTIVATE_DELAY_CYCLES
// before the final (activate) word so VMID can settle.
module codec_cfg_sequencer
   import codec_cfg_pkg::*;
#(
   parameter int          NUM_INIT_WORDS        = 10,
   parameter int          MAX_RETRY             = 3,
   parameter logic [23:0] ACTIVATE_DELAY_CYCLES = 24'd6_250_000
) (
   input  logic        board_clk,
   input  logic        reset,
   input  logic        init_start,
   input  logic        sw_valid,
   output logic        sw_ready,
   input  logic [6:0]  sw_addr,
   input  logic [8:0]  sw_data,
   output logic        i2c_valid,
   input  logic        i2c_ready,
   output logic [15:0] i2c_word,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        init_done,
   output logic        busy,
   output logic        error,
   output logic [6:0]  err_addr,
   output logic [7:0]  retry_cnt_total
);

   if (NUM_INIT_WORDS < 1 || NUM_INIT_WORDS > 16 || MAX_RETRY < 0 || MAX_RETRY > 7 ||
       ACTIVATE_DELAY_CYCLES == 24'd0) begin : g_param_chk
      $error("codec_cfg_sequencer: parameter out of range");
   end

   localparam logic [3:0] LAST_IDX = 4'(NUM_INIT_WORDS - 1);

   seq_state_t state, state_nxt;
   logic [3:0] idx;
   logic       pend_restart;
   logic       in_wait, go_restart, hs, sw_hs, done_ack, done_nack, exhausted, last_word;

   assign in_wait    = (state == INIT_WAIT) || (state == SW_WAIT);
   assign hs         = i2c_valid && i2c_ready;
   assign sw_hs      = sw_valid && sw_ready;
   assign done_ack   = in_wait && i2c_done && !i2c_nack;
   assign done_nack  = in_wait && i2c_done && i2c_nack;
   assign last_word  = (idx == LAST_IDX);
   // a restart during an issue is deferred to the end of that transaction
   assign go_restart = (init_start && !i2c_valid) || (pend_restart && in_wait && i2c_done);

   codec_retry_ctrl #(.MAX_RETRY(MAX_RETRY)) u_retry (
      .board_clk       (board_clk),
      .reset           (reset),
      .clr             ((state == INIT_LOAD) || sw_hs),
      .nack            (done_nack && !go_restart),
      .exhausted       (exhausted),
      .retry_cnt_total (retry_cnt_total)
   );

`ifdef CODEC_SEQ_ACTIVATE_DELAY_EN
   logic [23:0] dly_cnt;

   // settle timer, runs only while in INIT_DELAY
   always_ff @(posedge board_clk) begin
      if (reset || state != INIT_DELAY) dly_cnt <= '0;
      else                              dly_cnt <= dly_cnt + 24'd1;
   end
`endif

   // state register; init runs automatically out of reset
   always_ff @(posedge board_clk) begin
      if (reset) state <= INIT_LOAD;
      else       state <= state_nxt;
   end

   // next-state logic; init_start overrides everything once accepted
   always_comb begin
      state_nxt = state;
      if (go_restart) begin
         state_nxt = INIT_LOAD;
      end else begin
         unique case (state)
            IDLE:       if (sw_hs) state_nxt = SW_ISSUE;
`ifdef CODEC_SEQ_ACTIVATE_DELAY_EN
            INIT_LOAD:  state_nxt = last_word ? INIT_DELAY : INIT_ISSUE;
            INIT_DELAY: if (dly_cnt == ACTIVATE_DELAY_CYCLES - 24'd1) state_nxt = INIT_ISSUE;
`else
            INIT_LOAD:  state_nxt = INIT_ISSUE;
            INIT_DELAY: state_nxt = INIT_ISSUE;
`endif
            INIT_ISSUE: if (hs) state_nxt = INIT_WAIT;
            INIT_WAIT: begin
               if (done_ack)       state_nxt = last_word ? IDLE : INIT_LOAD;
               else if (done_nack) state_nxt = exhausted ? FAULT : INIT_ISSUE;
            end
            SW_ISSUE:   if (hs) state_nxt = SW_WAIT;
            SW_WAIT: begin
               if (done_ack)       state_nxt = IDLE;
               else if (done_nack) state_nxt = exhausted ? FAULT : SW_ISSUE;
            end
            FAULT:      state_nxt = FAULT;
            default:    state_nxt = INIT_LOAD;
         endcase
      end
   end

   // handshake outputs decoded from state; a same-cycle init_start blocks software
   always_comb begin
      i2c_valid = (state == INIT_ISSUE) || (state == SW_ISSUE);
      sw_ready  = (state == IDLE) && init_done && !init_start;
   end

   // busy is registered from the next state so it reads 0 while held in reset
   always_ff @(posedge board_clk) begin
      if (reset) busy <= 1'b0;
      else       busy <= !((state_nxt == IDLE) || (state_nxt == FAULT));
   end

   // word/index/status datapath
   always_ff @(posedge board_clk) begin
      if (reset) begin
         idx          <= '0;
         i2c_word     <= '0;
         pend_restart <= 1'b0;
         init_done    <= 1'b0;
         error        <= 1'b0;
         err_addr     <= '0;
      end else if (go_restart) begin
         idx          <= '0;
         pend_restart <= 1'b0;
         init_done    <= 1'b0;
         error        <= 1'b0;
         err_addr     <= '0;
      end else begin
         if (init_start && i2c_valid) pend_restart <= 1'b1;
         case (state)
            INIT_LOAD: i2c_word <= CODEC_INIT_TABLE[idx];
            IDLE:      if (sw_hs) i2c_word <= {sw_addr, sw_data};
            INIT_WAIT: begin
               if (done_ack) begin
                  idx <= idx + 4'd1;
                  if (last_word) init_done <= 1'b1;
               end else if (done_nack && exhausted) begin
                  error    <= 1'b1;
                  err_addr <= i2c_word[15:9];
               end
            end
            SW_WAIT: begin
               if (done_nack && exhausted) begin
                  error    <= 1'b1;
                  err_addr <= i2c_word[15:9];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer: expected I2C words are queued when
// stimulus is applied and popped at each I2C handshake. A small controller
// model answers every command with a done pulse and scripted NACKs.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;

   localparam logic [23:0] DLY = 24'd20;

   logic        board_clk = 1'b0;
   logic        reset, init_start, sw_valid, i2c_ready, i2c_done, i2c_nack;
   logic [6:0]  sw_addr;
   logic [8:0]  sw_data;
   logic        sw_ready, i2c_valid, init_done, busy, error;
   logic [15:0] i2c_word;
   logic [6:0]  err_addr;
   logic [7:0]  retry_cnt_total;

   always #4 board_clk = ~board_clk;

   codec_cfg_sequencer #(
      .NUM_INIT_WORDS        (10),
      .MAX_RETRY             (3),
      .ACTIVATE_DELAY_CYCLES (DLY)
   ) dut (
      .board_clk       (board_clk),
      .reset           (reset),
      .init_start      (init_start),
      .sw_valid        (sw_valid),
      .sw_ready        (sw_ready),
      .sw_addr         (sw_addr),
      .sw_data         (sw_data),
      .i2c_valid       (i2c_valid),
      .i2c_ready       (i2c_ready),
      .i2c_word        (i2c_word),
      .i2c_done        (i2c_done),
      .i2c_nack        (i2c_nack),
      .init_done       (init_done),
      .busy            (busy),
      .error           (error),
      .err_addr        (err_addr),
      .retry_cnt_total (retry_cnt_total)
   );

   // expected power-up words {addr, data}
   logic [15:0] tbl [10] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0479, 16'h0812,
                             16'h0A00, 16'h0E0A, 16'h1000, 16'h0C00, 16'h1201};

   int          n_chk = 0, n_pass = 0;
   logic [15:0] exp_q [$];
   logic [15:0] nack_word = 16'hFFFF;
   int          nack_left = 0;
   int          acc_cnt = 0, viol = 0, cyc = 0, last_hs = 0, act_gap = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   // monitor: scoreboard pop on I2C handshake, software accept count, sw_ready rule
   always @(negedge board_clk) begin
      cyc++;
      if (!reset) begin
         if (sw_ready && (busy || !init_done)) viol++;
         if (sw_valid && sw_ready) acc_cnt++;
         if (i2c_valid && i2c_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("i2c_word", i2c_word, exp_q.pop_front());
            if (i2c_word == 16'h1201) act_gap = cyc - last_hs;
            last_hs = cyc;
         end
      end
   end

   // I2C controller model: done pulse 4 cycles after each accepted command
   initial begin
      logic [15:0] w;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      forever begin
         @(negedge board_clk);
         if (!reset && i2c_valid && i2c_ready) begin
            w = i2c_word;
            @(posedge board_clk);
            repeat (3) @(posedge board_clk);
            #1;
            i2c_done = 1'b1;
            i2c_nack = 1'b0;
            if (w == nack_word && nack_left > 0) begin
               i2c_nack = 1'b1;
               nack_left--;
            end
            @(posedge board_clk);
            #1;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge board_clk);
      #1;
   endtask

   task automatic push_table();
      foreach (tbl[i]) exp_q.push_back(tbl[i]);
   endtask

   task automatic pulse_start();
      init_start = 1'b1;
      step();
      init_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      step(2);
      while (busy && k < 3000) begin
         step();
         k++;
      end
      chk({"idle_", tag}, busy, 0);
   endtask

   initial begin
      int a0;
      bit found;
      reset = 1'b1; init_start = 1'b0; sw_valid = 1'b0;
      sw_addr = '0; sw_data = '0; i2c_ready = 1'b0;

      // reset values
      repeat (3) @(posedge board_clk);
      @(negedge board_clk);
      chk("rst_i2c_valid", i2c_valid, 0);
      chk("rst_i2c_word", i2c_word, 0);
      chk("rst_sw_ready", sw_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_err_addr", err_addr, 0);
      chk("rst_retry_total", retry_cnt_total, 0);

      // automatic init, all ACK
      @(posedge board_clk); #1;
      reset = 1'b0;
      i2c_ready = 1'b1;
      push_table();
      wait_idle("init1");
      chk("init1_done", init_done, 1);
      chk("init1_error", error, 0);
      chk("init1_retry", retry_cnt_total, 0);
      chk("init1_q", exp_q.size(), 0);
      chk("init1_sw_ready", sw_ready, 1);
`ifdef CODEC_SEQ_ACTIVATE_DELAY_EN
      chk("act_gap_ok", 32'(act_gap >= int'(DLY)), 1);
`endif

      // word 2 NACKed twice then ACKed
      nack_word = tbl[2]; nack_left = 2;
      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i]);
         if (i == 2) begin exp_q.push_back(tbl[2]); exp_q.push_back(tbl[2]); end
      end
      pulse_start();
      wait_idle("nack2");
      chk("nack2_retry", retry_cnt_total, 2);
      chk("nack2_error", error, 0);
      chk("nack2_done", init_done, 1);
      chk("nack2_q", exp_q.size(), 0);

      // word 3 NACKed until retries run out
      nack_word = tbl[3]; nack_left = 4;
      for (int i = 0; i < 3; i++) exp_q.push_back(tbl[i]);
      repeat (4) exp_q.push_back(tbl[3]);
      pulse_start();
      wait_idle("fault");
      chk("fault_error", error, 1);
      chk("fault_err_addr", err_addr, 7'h02);
      chk("fault_sw_ready", sw_ready, 0);
      chk("fault_i2c_valid", i2c_valid, 0);
      chk("fault_done", init_done, 0);
      chk("fault_retry", retry_cnt_total, 5);
      chk("fault_q", exp_q.size(), 0);
      push_table();
      pulse_start();
      chk("restart_err_clr", error, 0);
      chk("restart_addr_clr", err_addr, 0);
      wait_idle("reinit");
      chk("reinit_done", init_done, 1);
      chk("reinit_q", exp_q.size(), 0);

      // single software write
      a0 = acc_cnt;
      sw_addr = 7'h04; sw_data = 9'h012; sw_valid = 1'b1;
      exp_q.push_back(16'h0812);
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge board_clk);
         if (sw_ready) found = 1;
      end
      chk("sw_accept", found, 1);
      @(posedge board_clk); #1;
      sw_valid = 1'b0;
      @(negedge board_clk);
      chk("sw_busy", busy, 1);
      chk("sw_ready_low", sw_ready, 0);
      wait_idle("sw");
      chk("sw_ready_back", sw_ready, 1);
      chk("sw_acc", acc_cnt - a0, 1);
      chk("sw_q", exp_q.size(), 0);

      // init_start beats a same-cycle software request, which waits for init_done
      a0 = acc_cnt;
      sw_addr = 7'h05; sw_data = 9'h006; sw_valid = 1'b1;
      init_start = 1'b1;
      push_table();
      exp_q.push_back(16'h0A06);
      step();
      init_start = 1'b0;
      found = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge board_clk);
         if (sw_ready) found = 1;
      end
      chk("blk_accept", found, 1);
      @(posedge board_clk); #1;
      sw_valid = 1'b0;
      wait_idle("blk");
      chk("blk_acc", acc_cnt - a0, 1);
      chk("blk_q", exp_q.size(), 0);

      // init_start during a stalled issue is deferred until that word completes
      i2c_ready = 1'b0;
      exp_q.push_back(tbl[0]);
      push_table();
      pulse_start();
      step(3);
      chk("stall_valid", i2c_valid, 1);
      chk("stall_word", i2c_word, tbl[0]);
      pulse_start();
      step(3);
      chk("hold_word", i2c_word, tbl[0]);
      chk("hold_valid", i2c_valid, 1);
      chk("hold_busy", busy, 1);
      i2c_ready = 1'b1;
      wait_idle("defer");
      chk("defer_done", init_done, 1);
      chk("defer_q", exp_q.size(), 0);
      chk("sw_ready_rule", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
